// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and the request decode helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Stores only support the signed width codes; loads add the unsigned ones.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Bits [1:0] of funct3 encode the access size for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] be_gen(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic [3:0] be;
    be = BE_WORD;
    if (we && f3 == F3_B) be = 4'b0001 << off;
    else if (we && f3 == F3_H) be = off[1] ? BE_HALF_HI : BE_HALF_LO;
    return be;
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a memory word for a load.
// Purely combinational so the single-cycle dmem path can share it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'd0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'd0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a variable-latency data memory:
// decode/alignment check, byte enables, req/ready handshake with timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output state_e      dbg_state
);

  // Memory handshake: mem_req rises on entry to ACCESS and every mem_* output
  // holds until the cycle mem_ready is sampled high (or the timeout fires);
  // mem_ready is ignored in every other state.

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] load_data;

  load_extend u_load_extend (
    .word   (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    off_d       = off_q;
    f3_d        = f3_q;
    case (state_q)
      S_IDLE: begin
        cnt_d       = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (req_valid) begin
          if (!f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0])) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = be_gen(req_we, req_funct3, req_addr[1:0]);
            mem_wdata_d = req_we ? wdata_gen(req_funct3, req_wdata) : 32'd0;
            off_d       = req_addr[1:0];
            f3_d        = req_funct3;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // A ready arriving in the timeout cycle still completes normally.
        if (mem_ready) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_we_q ? 32'd0 : load_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      off_q       <= '0;
      f3_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
    end
  end

  assign stall     = req_valid & (state_q != S_DONE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver issues requests and plays the
// memory, a negedge monitor checks every response against a scoreboard queue.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  state_e      dbg_state;

  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Response monitor: one pop per rsp_valid pulse.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {rsp_err, rsp_rdata}, 33'h0);
      else check("rsp_data", {rsp_err, rsp_rdata}, exp_q.pop_front());
    end
  end

  // waits < 0 means the memory never answers.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] mrdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_lat, input int exp_nreq,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int cyc, nreq;
    bit done;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1 check({tag, "_stall_c0"}, {32'd0, stall}, 33'd1);
    cyc = 0; nreq = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        check({tag, "_latency"}, 33'(cyc), 33'(exp_lat));
        check({tag, "_stall_done"}, {32'd0, stall}, 33'd0);
        check({tag, "_mem_req_cycles"}, 33'(nreq), 33'(exp_nreq));
        done = 1;
      end else begin
        check({tag, "_stall_wait"}, {32'd0, stall}, 33'd1);
        if (mem_req) begin
          check({tag, "_mem_addr"}, {1'b0, mem_addr}, {1'b0, addr[31:2], 2'b00});
          check({tag, "_mem_be_we"}, {28'd0, mem_we, mem_be}, {28'd0, we, exp_be});
          check({tag, "_mem_wdata"}, {1'b0, mem_wdata}, {1'b0, exp_wdata});
          mem_ready = (waits >= 0) && (nreq == waits);
          mem_rdata = mem_ready ? mrdata : 32'hA5A5_A5A5;
          nreq++;
        end else begin
          mem_ready = 1'b0;
        end
        if (cyc > 40) begin
          check({tag, "_rsp_timeout"}, 33'd0, 33'd1);
          done = 1;
        end
      end
    end
    mem_ready = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_rsp_pulse"}, {32'd0, rsp_valid}, 33'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    #1;
    check("reset_outputs", {mem_req, mem_we, mem_be, rsp_valid, rsp_err, 25'd0},
          33'd0);
    check("reset_buses", {1'b0, mem_addr | mem_wdata | rsp_rdata}, 33'd0);
    check("reset_state", {31'd0, dbg_state}, {31'd0, S_IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    //       tag     we  f3     addr         wdata        waits rdata         err  exp_rdata     lat nreq be       wdata
    run_req("lb",    0, F3_B,  32'h1003, 32'h0,        0, 32'h80FF_1234, 0, 32'hFFFF_FF80, 2, 1, 4'b1111, 32'h0);
    run_req("lhu",   0, F3_HU, 32'h2002, 32'h0,        3, 32'hBEEF_0000, 0, 32'h0000_BEEF, 5, 4, 4'b1111, 32'h0);
    run_req("sb",    1, F3_B,  32'h3001, 32'h0000_00AB, 0, 32'hFFFF_FFFF, 0, 32'h0,         2, 1, 4'b0010, 32'hABAB_ABAB);
    run_req("sw_mis",1, F3_W,  32'h4002, 32'h1111_2222, 0, 32'h0,         1, 32'h0,         1, 0, 4'b1111, 32'h0);
    run_req("ld_011",0, 3'b011,32'h4000, 32'h0,        0, 32'h0,         1, 32'h0,         1, 0, 4'b1111, 32'h0);
    run_req("lw_to", 0, F3_W,  32'h5000, 32'h0,       -1, 32'h0,         1, 32'h0,         5, 4, 4'b1111, 32'h0);
    run_req("lw",    0, F3_W,  32'h6000, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 3, 2, 4'b1111, 32'h0);
    run_req("lh",    0, F3_H,  32'h7002, 32'h0,        0, 32'h8001_7FFF, 0, 32'hFFFF_8001, 2, 1, 4'b1111, 32'h0);
    run_req("lh_lo", 0, F3_H,  32'h7000, 32'h0,        0, 32'h8001_7FFF, 0, 32'h0000_7FFF, 2, 1, 4'b1111, 32'h0);
    run_req("lbu",   0, F3_BU, 32'h8001, 32'h0000_F000, 0, 32'h0000_F000, 0, 32'h0000_00F0, 2, 1, 4'b1111, 32'h0);
    run_req("sh",    1, F3_H,  32'h9002, 32'h1234_CAFE, 2, 32'hFFFF_FFFF, 0, 32'h0,         4, 3, 4'b1100, 32'hCAFE_CAFE);
    run_req("sb_st", 1, F3_B,  32'h9003, 32'h1234_5677, 0, 32'h0,         0, 32'h0,         2, 1, 4'b1000, 32'h7777_7777);
    run_req("st_100",1, F3_BU, 32'hA000, 32'h0,        0, 32'h0,         1, 32'h0,         1, 0, 4'b1111, 32'h0);
    run_req("lh_mis",0, F3_H,  32'hA001, 32'h0,        0, 32'h0,         1, 32'h0,         1, 0, 4'b1111, 32'h0);

    // Reset in the middle of an SH access: everything clears asynchronously.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'hB000; req_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    check("rst_pre_req", {32'd0, mem_req}, 33'd1);
    check("rst_pre_be", {29'd0, mem_be}, {29'd0, BE_HALF_LO});
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ctrl", {mem_req, mem_we, mem_be, rsp_valid, rsp_err, 25'd0}, 33'd0);
    check("rst_mid_bus", {1'b0, mem_addr | mem_wdata | rsp_rdata}, 33'd0);
    check("rst_mid_state", {31'd0, dbg_state}, {31'd0, S_IDLE});
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    run_req("lw_post",0, F3_W, 32'hC004, 32'h0,        0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 2, 1, 4'b1111, 32'h0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 33'(exp_q.size()), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the pipeline MEM stage and data memory.
- Checks alignment and funct3 legality per access.
- Builds byte enables and lane-replicated write data.
- Runs a request/ready handshake with a variable-latency memory.
- Returns sign- or zero-extended load data and stalls the pipeline while an access is outstanding.

Parameters:
- TIMEOUT, 255, max cycles in ACCESS waiting for mem_ready before a bus error (1..65535).
- CNT_W, 16, width of the timeout counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM stage holds a load/store.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  freeze pipeline (hold request stable).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data (0 for stores/errors).
- rsp_err  out  1  misaligned, illegal or timeout.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word address ({req_addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  memory accepted/completed this cycle.
- mem_rdata  in  32  read word, valid with mem_ready.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (async): state=IDLE, counter=0, and all registered outputs 0 (rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata, mem_be).
- stall = req_valid & (state != DONE), combinational.
- IDLE, req_valid=1:
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Anything else is illegal.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned -> DONE with rsp_err=1, rsp_rdata=0; mem_req never asserted.
  - Otherwise latch the request and go to ACCESS with mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata registered.
- Byte enables:
  - SB: 1<<addr[1:0].
  - SH: 0011 if addr[1]=0, else 1100.
  - SW and all loads: 1111.
- mem_wdata: SB = byte x4, SH = half x2, SW = word.
- ACCESS:
  - mem_req and all mem_* signals stable until mem_ready.
  - On mem_ready: drop mem_req, capture the extended load into rsp_rdata (stores give 0), rsp_err=0, go to DONE.
  - Counter increments each ACCESS cycle. When counter == TIMEOUT-1 and mem_ready=0: drop mem_req, rsp_err=1, rsp_rdata=0, go to DONE.
  - mem_ready in the same cycle as the timeout wins: normal completion.
- Load extension: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- DONE: rsp_valid=1 for exactly one cycle, stall=0 so the pipeline advances; next state IDLE, counter cleared.
- Latency:
  - Error: response 1 cycle after request.
  - Memory with mem_ready in its first ACCESS cycle: response 2 cycles after request.
  - Each extra wait cycle adds 1.
- No back-to-back issue: at least one IDLE cycle between accesses.
- mem_ready outside ACCESS is ignored.
- req_valid dropping or request fields changing during ACCESS is a protocol violation. The access completes using the latched values and the response is still pulsed.
- Reset mid-ACCESS: mem_req drops immediately (async). Memory must tolerate an abandoned request.

Decomposition:
- Shared package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, BE constants (BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100).
- Sub-module load_extend, combinational: (word, addr[1:0], funct3) -> 32-bit extended data. Reusable by the single-cycle dmem path.

Test Plan:
- LB at 0x1003, mem_rdata=0x80FF_1234, ready on first ACCESS cycle -> rsp_valid at cycle 2, rsp_rdata=0xFFFF_FF80, mem_addr=0x1000, mem_be=1111, stall high for cycles 0-1.
- LHU at 0x2002, mem_rdata=0xBEEF_0000, ready after 3 waits -> rsp_rdata=0x0000_BEEF at cycle 5; mem_req stable for 4 cycles.
- SB 0x000000AB at 0x3001 -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB; rsp_rdata=0, rsp_err=0.
- SW at 0x4002 (misaligned) -> rsp_valid and rsp_err at cycle 1, mem_req never high. funct3=011 load -> same response.
- LW with mem_ready tied 0, TIMEOUT=4 -> mem_req high for 4 cycles, then rsp_err=1, rsp_rdata=0; next request accepted normally.
- Assert reset during ACCESS of an SH -> mem_req, stall-relevant state and all outputs 0 the same cycle; post-reset LW completes correctly.
